// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
//   FWD_*   : operand select encodings driven to the decode stage
//   REG_W   : register number width
//   stage_t : per-stage scoreboard entry {valid, writes rf, dest, is load}
package pipe_pkg;

    localparam int unsigned REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic             v;
        logic             we;
        logic [REG_W-1:0] dst;
        logic             ld;
    } stage_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Decode-side bundle between the ID stage and pipe_ctrl.
//   master : decode side, drives the ID instruction fields and flush
//   slave  : pipe_ctrl, returns enables, bypass selects, stage status, counters
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipe_pkg::*;

    logic             id_src1_en;
    logic [REG_W-1:0] id_src1;
    logic             id_src2_en;
    logic [REG_W-1:0] id_src2;
    logic             id_dst_we;
    logic [REG_W-1:0] id_dst;
    logic             id_is_load;
    logic             flush;

    logic             pc_we;
    logic             if_id_we;
    logic             id_ex_bubble;
    logic [1:0]       fwd1_sel;
    logic [1:0]       fwd2_sel;
    logic             ex_valid;
    logic             mem_valid;
    logic             wb_valid;
    logic             wb_rf_we;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output id_src1_en, id_src1, id_src2_en, id_src2,
               id_dst_we, id_dst, id_is_load, flush,
        input  pc_we, if_id_we, id_ex_bubble, fwd1_sel, fwd2_sel,
               ex_valid, mem_valid, wb_valid, wb_rf_we, stall_cnt, retire_cnt
    );

    modport slave (
        input  id_src1_en, id_src1, id_src2_en, id_src2,
               id_dst_we, id_dst, id_is_load, flush,
        output pc_we, if_id_we, id_ex_bubble, fwd1_sel, fwd2_sel,
               ex_valid, mem_valid, wb_valid, wb_rf_we, stall_cnt, retire_cnt
    );

endinterface

// File: rtl/pipe_fwd_sel.sv
// Bypass select for one source operand.
//   src_en    : source is read by a live ID instruction
//   src       : source register number
//   ex_s/mem_s/wb_s : stage scoreboards
//   sel       : operand select, priority EX > MEM > WB > regfile
//   ex_ld_hit : source matches a load sitting in EX (load-use)
module pipe_fwd_sel
    import pipe_pkg::*;
(
    input  logic             src_en,
    input  logic [REG_W-1:0] src,
    input  stage_t           ex_s,
    input  stage_t           mem_s,
    input  stage_t           wb_s,
    output logic [1:0]       sel,
    output logic             ex_ld_hit
);

    logic src_live;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;
    logic unused_ld;

    // $0 is hardwired, so it never matches a producer
    assign src_live = src_en & (src != '0);

    assign hit_ex  = src_live & ex_s.v  & ex_s.we  & (ex_s.dst  == src);
    assign hit_mem = src_live & mem_s.v & mem_s.we & (mem_s.dst == src);
    assign hit_wb  = src_live & wb_s.v  & wb_s.we  & (wb_s.dst  == src);

    assign ex_ld_hit = hit_ex & ex_s.ld;

    // Load flag only matters while the producer is in EX
    assign unused_ld = mem_s.ld ^ wb_s.ld;

    // Youngest producer wins
    always_comb begin
        sel = FWD_RF;
        if (hit_ex) begin
            sel = FWD_EX;
        end else if (hit_mem) begin
            sel = FWD_MEM;
        end else if (hit_wb) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencing controller.
//   clk, rst : core clock, async active-high reset
//   bus      : pipe_ctrl_if slave; ID instruction fields + flush in,
//              PC/IF-ID enables, ID/EX bubble, bypass selects,
//              EX/MEM/WB valids, WB write gate and debug counters out
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    stage_t           ex_q;
    stage_t           mem_q;
    stage_t           wb_q;
    stage_t           ex_d;
    logic             id_v_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] retire_cnt_q;

    logic             ld_hit1;
    logic             ld_hit2;
    logic             stall;

    pipe_fwd_sel u_fwd1 (
        .src_en    (id_v_q & bus.id_src1_en),
        .src       (bus.id_src1),
        .ex_s      (ex_q),
        .mem_s     (mem_q),
        .wb_s      (wb_q),
        .sel       (bus.fwd1_sel),
        .ex_ld_hit (ld_hit1)
    );

    pipe_fwd_sel u_fwd2 (
        .src_en    (id_v_q & bus.id_src2_en),
        .src       (bus.id_src2),
        .ex_s      (ex_q),
        .mem_s     (mem_q),
        .wb_s      (wb_q),
        .sel       (bus.fwd2_sel),
        .ex_ld_hit (ld_hit2)
    );

    // Flush kills the dependent itself, so it overrides the load-use stall
    assign stall = (ld_hit1 | ld_hit2) & ~bus.flush;

    // Entry for EX: a bubble whenever ID is empty, stalled or flushed
    always_comb begin
        ex_d     = '0;
        ex_d.v   = id_v_q & ~stall & ~bus.flush;
        ex_d.we  = bus.id_dst_we;
        ex_d.dst = bus.id_dst;
        ex_d.ld  = bus.id_is_load;
    end

    // Stage scoreboards, ID valid and saturating debug counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            id_v_q       <= 1'b0;
            stall_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (!stall) begin
                id_v_q <= ~bus.flush;
            end
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (wb_q.v && (retire_cnt_q != '1)) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc_we        = ~stall;
    assign bus.if_id_we     = ~stall;
    assign bus.id_ex_bubble = stall | bus.flush | ~id_v_q;
    assign bus.ex_valid     = ex_q.v;
    assign bus.mem_valid    = mem_q.v;
    assign bus.wb_valid     = wb_q.v;
    assign bus.wb_rf_we     = wb_q.v & wb_q.we;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a per-cycle vector table pushed through a
// scoreboard queue, plus hand sequences for async reset and counter saturation.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic       s1e;
        logic [4:0] s1;
        logic       s2e;
        logic [4:0] s2;
        logic       we;
        logic [4:0] dst;
        logic       ld;
        logic       fl;
    } in_t;

    typedef struct packed {
        logic        pc;
        logic        bub;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic        ex;
        logic        mem;
        logic        wb;
        logic        rf;
        logic [15:0] sc;
        logic [15:0] rc;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    localparam int unsigned NV = 18;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vec [NV];
    exp_t sb_q [$];

    pipe_ctrl_if #(.CNT_W(16)) bus  ();
    pipe_ctrl_if #(.CNT_W(4))  bus4 ();

    pipe_ctrl #(.CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pipe_ctrl #(.CNT_W(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t ins(input logic s1e, input int s1, input logic s2e, input int s2,
                                input logic we, input int dst, input logic ld, input logic fl);
        in_t r;
        r.s1e = s1e; r.s1 = 5'(s1); r.s2e = s2e; r.s2 = 5'(s2);
        r.we = we; r.dst = 5'(dst); r.ld = ld; r.fl = fl;
        return r;
    endfunction

    function automatic exp_t ex(input logic pc, input logic bub, input int f1, input int f2,
                                input logic e, input logic m, input logic w, input logic rf,
                                input int sc, input int rc);
        exp_t r;
        r.pc = pc; r.bub = bub; r.f1 = 2'(f1); r.f2 = 2'(f2);
        r.ex = e; r.mem = m; r.wb = w; r.rf = rf;
        r.sc = 16'(sc); r.rc = 16'(rc);
        return r;
    endfunction

    task automatic apply(input in_t i);
        bus.id_src1_en  = i.s1e;  bus4.id_src1_en  = i.s1e;
        bus.id_src1     = i.s1;   bus4.id_src1     = i.s1;
        bus.id_src2_en  = i.s2e;  bus4.id_src2_en  = i.s2e;
        bus.id_src2     = i.s2;   bus4.id_src2     = i.s2;
        bus.id_dst_we   = i.we;   bus4.id_dst_we   = i.we;
        bus.id_dst      = i.dst;  bus4.id_dst      = i.dst;
        bus.id_is_load  = i.ld;   bus4.id_is_load  = i.ld;
        bus.flush       = i.fl;   bus4.flush       = i.fl;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".pc_we"},        32'(bus.pc_we),        32'(e.pc));
        chk({tag, ".if_id_we"},     32'(bus.if_id_we),     32'(e.pc));
        chk({tag, ".id_ex_bubble"}, 32'(bus.id_ex_bubble), 32'(e.bub));
        chk({tag, ".fwd1_sel"},     32'(bus.fwd1_sel),     32'(e.f1));
        chk({tag, ".fwd2_sel"},     32'(bus.fwd2_sel),     32'(e.f2));
        chk({tag, ".ex_valid"},     32'(bus.ex_valid),     32'(e.ex));
        chk({tag, ".mem_valid"},    32'(bus.mem_valid),    32'(e.mem));
        chk({tag, ".wb_valid"},     32'(bus.wb_valid),     32'(e.wb));
        chk({tag, ".wb_rf_we"},     32'(bus.wb_rf_we),     32'(e.rf));
        chk({tag, ".stall_cnt"},    32'(bus.stall_cnt),    32'(e.sc));
        chk({tag, ".retire_cnt"},   32'(bus.retire_cnt),   32'(e.rc));
    endtask

    initial begin
        exp_t e;
        in_t  idle;
        int   exp_sat;
        checks = 0;
        errors = 0;
        idle   = ins(0, 0, 0, 0, 0, 0, 0, 0);

        // in : s1e s1 s2e s2 we dst ld fl
        // exp: pc bub f1 f2 ex mem wb rf stall_cnt retire_cnt
        vec[0]  = '{ins(0,0,0,0,0,0,0,0), ex(1,1,0,0,0,0,0,0,0,0)}; // id_v still 0
        vec[1]  = '{ins(1,1,1,2,1,3,0,0), ex(1,0,0,0,0,0,0,0,0,0)}; // addu $3<-$1,$2
        vec[2]  = '{ins(1,3,1,3,1,4,0,0), ex(1,0,1,1,1,0,0,0,0,0)}; // addu $4<-$3,$3
        vec[3]  = '{ins(1,4,0,0,1,5,1,0), ex(1,0,1,0,1,1,0,0,0,0)}; // lw $5 <- ($4)
        vec[4]  = '{ins(1,5,1,0,1,6,0,0), ex(0,1,1,0,1,1,1,1,0,0)}; // addu $6<-$5,$0 stall
        vec[5]  = '{ins(1,5,1,0,1,6,0,0), ex(1,0,2,0,0,1,1,1,1,1)}; // same, load in MEM
        vec[6]  = '{ins(1,5,1,6,1,0,1,0), ex(1,0,3,1,1,0,1,1,1,2)}; // lw $0, reads $5,$6
        vec[7]  = '{ins(1,0,1,0,0,0,0,0), ex(1,0,0,0,1,1,0,0,1,3)}; // reads $0 after lw $0
        vec[8]  = '{ins(1,6,0,0,1,7,1,0), ex(1,0,3,0,1,1,1,1,1,3)}; // lw $7 <- ($6)
        vec[9]  = '{ins(1,7,1,7,1,9,0,1), ex(1,1,1,1,1,1,1,1,1,4)}; // load-use + flush
        vec[10] = '{ins(1,7,1,7,1,9,0,1), ex(1,1,0,0,0,1,1,0,1,5)}; // second flush
        vec[11] = '{ins(0,0,0,0,0,0,0,0), ex(1,1,0,0,0,0,1,1,1,6)}; // flushed load in WB
        vec[12] = '{ins(1,0,0,0,1,8,1,0), ex(1,0,0,0,0,0,0,0,1,7)}; // lw $8 <- ($0)
        vec[13] = '{ins(1,8,1,8,1,9,0,0), ex(0,1,1,1,1,0,0,0,1,7)}; // both srcs on EX load
        vec[14] = '{ins(1,8,1,8,1,9,0,0), ex(1,0,2,2,0,1,0,0,2,7)}; // single stall only
        vec[15] = '{ins(1,8,1,9,0,0,0,0), ex(1,0,3,1,1,0,1,1,2,7)}; // WB and EX bypass
        vec[16] = '{ins(0,0,0,0,0,0,0,0), ex(1,0,0,0,1,1,0,0,2,8)};
        vec[17] = '{ins(0,0,0,0,0,0,0,0), ex(1,0,0,0,1,1,1,1,2,8)};

        // Reset held three cycles
        rst = 1'b1;
        apply(idle);
        @(negedge clk);
        chk_all("reset", ex(1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Table: drive + push, sample on falling edge + pop
        for (int i = 0; i < int'(NV); i++) begin
            apply(vec[i].in);
            sb_q.push_back(vec[i].ex);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d.sb_empty", i), 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk_all($sformatf("v%0d", i), e);
            end
            @(posedge clk);
            #1;
        end

        // Counters after the table
        apply(idle);
        @(negedge clk);
        chk("post.stall_cnt",  32'(bus.stall_cnt),  32'd2);
        chk("post.retire_cnt", 32'(bus.retire_cnt), 32'd9);

        // Async reset mid-operation, checked before any clock edge
        #2 rst = 1'b1;
        #1;
        chk("arst.ex_valid",   32'(bus.ex_valid),     32'd0);
        chk("arst.mem_valid",  32'(bus.mem_valid),    32'd0);
        chk("arst.wb_valid",   32'(bus.wb_valid),     32'd0);
        chk("arst.stall_cnt",  32'(bus.stall_cnt),    32'd0);
        chk("arst.retire_cnt", 32'(bus.retire_cnt),   32'd0);
        chk("arst.bubble",     32'(bus.id_ex_bubble), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel.retire_cnt", 32'(bus.retire_cnt), 32'd0);
        chk("rel.bubble",     32'(bus.id_ex_bubble), 32'd1);
        @(posedge clk);
        #1;

        // 20 load-use pairs; 4-bit counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            apply(ins(0, 0, 0, 0, 1, 5, 1, 0));
            @(negedge clk);
            chk($sformatf("sat%0d.ld_pc_we", k), 32'(bus4.pc_we), 32'd1);
            @(posedge clk);
            #1;
            apply(ins(1, 5, 0, 0, 1, 6, 0, 0));
            @(negedge clk);
            chk($sformatf("sat%0d.stall_pc_we", k), 32'(bus4.pc_we),        32'd0);
            chk($sformatf("sat%0d.stall_bub", k),   32'(bus4.id_ex_bubble), 32'd1);
            @(posedge clk);
            #1;
            @(negedge clk);
            exp_sat = (k > 15) ? 15 : k;
            chk($sformatf("sat%0d.fwd1", k),       32'(bus4.fwd1_sel),  32'd2);
            chk($sformatf("sat%0d.cnt4", k),       32'(bus4.stall_cnt), 32'(exp_sat));
            chk($sformatf("sat%0d.cnt16", k),      32'(bus.stall_cnt),  32'(k));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage CPU core. It tracks a valid/destination scoreboard for the EX, MEM and WB stages. It generates the PC, IF/ID and ID/EX enables, inserts a bubble on load-use hazards and drops wrong-path instructions on flush. It also drives the per-source bypass selects that the decode stage uses to pick register operands, and keeps saturating stall and retire counters for debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and retire counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_src1_en  in  1  ID instruction reads source 1
- id_src1  in  5  source 1 register number
- id_src2_en  in  1  ID instruction reads source 2
- id_src2  in  5  source 2 register number
- id_dst_we  in  1  ID instruction writes the register file
- id_dst  in  5  ID destination register
- id_is_load  in  1  ID instruction is a load
- flush  in  1  discard the ID instruction and the next fetch
- pc_we  out  1  PC may advance
- if_id_we  out  1  IF/ID register may load
- id_ex_bubble  out  1  ID/EX loads a NOP (valid=0) this cycle
- fwd1_sel  out  2  source 1 operand select
- fwd2_sel  out  2  source 2 operand select
- ex_valid, mem_valid, wb_valid  out  1 each  stage holds a live instruction
- wb_rf_we  out  1  wb_valid & WB write-enable; gates the regfile write port
- stall_cnt  out  CNT_W  cycles with stall=1, saturating
- retire_cnt  out  CNT_W  cycles with wb_valid=1, saturating

## Operation
- State per stage: EX {v, we, dst, ld}, MEM {v, we, dst, ld}, WB {v, we, dst}, plus id_v.
- hit_S_k = id_v & srck_en & (srck != 0) & S.v & S.we & (S.dst == srck).
- load_use = (hit_EX_1 | hit_EX_2) & EX.ld.
- stall = load_use & ~flush.
- Bypass select, priority EX > MEM > WB > regfile:
  - EX hit gives 1.
  - Else MEM hit gives 2.
  - Else WB hit gives 3.
  - Else 0.
  - Select values are computed regardless of stall; the consumer ignores them while stalled.
- Register $0 never hits, so its select is always 0.
- Combinational outputs:
  - pc_we = if_id_we = ~stall.
  - id_ex_bubble = stall | flush | ~id_v.
- Stage advance each edge:
  - MEM ← EX and WB ← MEM, always.
  - EX ← {id_v & ~stall & ~flush, id_dst_we, id_dst, id_is_load}.
  - id_v ← ~flush when ~stall; holds when stall.
- Flush has precedence over stall:
  - The ID instruction is dropped and no bubble-stall occurs.
  - Older instructions in EX/MEM/WB complete.
- Counters:
  - stall_cnt += 1 when stall.
  - retire_cnt += 1 when wb_valid.
  - Both hold at 2^CNT_W−1.

## Timing
- Reset (async): all stage v bits, id_v and both counters are 0.
- Outputs during reset:
  - ex_valid = mem_valid = wb_valid = wb_rf_we = 0.
  - pc_we = if_id_we = 1.
  - id_ex_bubble = 1.
  - fwd sels = 0.
- First edge after reset deassertion: id_v = 1.
- Reset asserted mid-operation clears everything immediately; in-flight instructions are lost, not retired.
- Load-use penalty is exactly 1 cycle:
  - Load in ID at cycle t, dependent in ID at t+1.
  - At t+1: stall = 1.
  - At t+2: dependent still in ID, load in MEM, fwdk_sel = 2, stall = 0.
- A load two instructions ahead of its consumer causes no stall; fwd_sel = 2.
- Both sources hitting the same EX load still give a single 1-cycle stall.
- A flush in a cycle with load_use forces stall = 0 and id_ex_bubble = 1; the PC advances.
- Back-to-back flushes keep id_v = 0 and keep inserting bubbles.
- Latency ID→WB for a non-stalled instruction: 3 edges.

## Structure
- Package pipe_pkg holds:
  - FWD_RF=2'd0, FWD_EX=2'd1, FWD_MEM=2'd2, FWD_WB=2'd3.
  - REG_W=5.
  - A stage-scoreboard struct {v, we, dst, ld}.
- Sub-module pipe_fwd_sel:
  - Takes one source (en, num) and the three stage scoreboards.
  - Returns the select and the EX-load hit.
  - Instantiated twice, once for src1 and once for src2.
- Counters, stage registers and id_v live in pipe_ctrl.

## Test plan
- Reset held for 3 cycles, then released:
  - During reset: pc_we = 1, all valids 0, counters 0.
  - One edge after release: id_v = 1; ex_valid becomes 1 on the following edge.
- Dependent ALU chain (addu $3←$1,$2; addu $4←$3,$3):
  - Second instruction sees fwd1_sel = fwd2_sel = 1.
  - No stall; retire_cnt increments by 2 as both reach WB.
- lw $5 then addu $6←$5,$0:
  - Exactly one cycle with pc_we = 0 and id_ex_bubble = 1.
  - Next cycle fwd1_sel = 2; stall_cnt = 1.
- Write to $0 followed by a reader of $0 → fwd sel stays 0 and there is no stall, even when the write is a load.
- flush asserted in the same cycle as a load_use:
  - stall = 0, pc_we = 1, id_ex_bubble = 1.
  - ex_valid = 0 next cycle; the older load still reaches WB with wb_rf_we = 1.
- CNT_W = 4 with 20 consecutive load-use pairs → stall_cnt saturates at 15 and holds.
